// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB-Lite slave-side bus bundle between the arbiter/decoder and one SRAM slave.
interface ahb_sram_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready_in;
    logic        hready_out;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready_in,
        output hready_out, hresp, hrdata
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready_in,
        input  hready_out, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite word SRAM slave with configurable wait states.
// Define AHB_SRAM_ERR_RESP_EN to add the two-cycle ERROR response for illegal accesses.
module ahb_sram_slave #(
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ADDR_MASK   = 32'h0000_FFFF
) (
    input  logic            hclk,
    input  logic            hreset,
    ahb_sram_slave_if.slave bus
);
    localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;

`ifdef AHB_SRAM_ERR_RESP_EN
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;
`endif

    state_t        r_state, w_next, w_go;
    logic [31:0]   r_mem [MEM_DEPTH];
    logic [31:0]   r_addr;
    logic          r_write;
    logic [2:0]    r_size;
    logic [3:0]    r_cnt;
    logic [31:0]   w_addr;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_be;
    logic          w_ready, w_accept;

    assign w_addr   = bus.haddr & ADDR_MASK;
    assign w_accept = w_ready && bus.hsel && bus.htrans[1] && bus.hready_in;
    assign w_idx    = AW'((r_addr >> 2) % 32'(MEM_DEPTH));
    assign w_be     = r_size == 3'b000 ? 4'b0001 << r_addr[1:0] :
                      r_size == 3'b001 ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;

`ifdef AHB_SRAM_ERR_RESP_EN
    logic w_err;
    assign w_err = w_addr >= 32'(MEM_DEPTH * 4) || bus.hsize > 3'b010 ||
                   (bus.hsize == 3'b001 && w_addr[0]) ||
                   (bus.hsize == 3'b010 && w_addr[1:0] != 2'b00);
    assign w_go      = w_err ? S_ERR1 : (WAIT_STATES > 0 ? S_WAIT : S_DATA);
    assign w_ready   = r_state != S_WAIT && r_state != S_ERR1;
    assign bus.hresp = {1'b0, r_state == S_ERR1 || r_state == S_ERR2};
`else
    assign w_go      = WAIT_STATES > 0 ? S_WAIT : S_DATA;
    assign w_ready   = r_state != S_WAIT;
    assign bus.hresp = 2'b00;
`endif

    assign bus.hready_out = w_ready;
    // Combinational read so a write committed on the previous edge is seen at once
    assign bus.hrdata = (r_state == S_DATA && !r_write) ? r_mem[w_idx] : 32'd0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT:  w_next = r_cnt == 4'd0 ? S_DATA : S_WAIT;
`ifdef AHB_SRAM_ERR_RESP_EN
            S_ERR1:  w_next = S_ERR2;
`endif
            default: w_next = w_accept ? w_go : S_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hreset) begin
        if (!hreset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_WAIT && r_cnt != 4'd0) ? r_cnt - 4'd1 :
                       (r_state != S_WAIT && w_next == S_WAIT) ? 4'(WAIT_STATES - 1) : r_cnt;
            if (w_accept) begin
                r_addr  <= w_addr;
                r_write <= bus.hwrite;
                r_size  <= bus.hsize;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (r_state == S_DATA && r_write)
            for (int i = 0; i < 4; i++)
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
    end
endmodule
